// File: rtl/spi_tx_pkg.sv
// Shared definitions for the 125 kHz SPI frame transmitter.
//   - state_t   : FSM state encoding (3-bit)
//   - DATA_W_DEF: default frame width in bits
//   - CNT_W_DEF : bit-counter width for the default frame width
//   - cnt_w()   : bit-counter width for an arbitrary frame width
package spi_tx_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned CNT_W_DEF  = $clog2(DATA_W_DEF);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOW   = 3'd1,
    HIGH  = 3'd2,
    TRAIL = 3'd3,
    GAP   = 3'd4
  } state_t;

  // Counter width able to index bits 0..w-1 (never narrower than 1 bit).
  function automatic int unsigned cnt_w(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/tick_edge_det.sv
// Rising-edge detector for the 125 kHz divider output.
// Turns the slow square wave into a one-clk_in-cycle event pulse.
// tick_q resets high so a tick already high at reset release is not an event.
//   clk_in     : 50 MHz system clock
//   rst        : synchronous reset, active-low
//   tick_in    : 125 kHz square wave (synchronous to clk_in)
//   tick_evt_c : combinational event pulse, high for one cycle per rising edge
module tick_edge_det (
  input  logic clk_in,
  input  logic rst,
  input  logic tick_in,
  output logic tick_evt_c
);

  logic tick_q;

  // Previous tick sample.
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      tick_q <= 1'b1;
    end else begin
      tick_q <= tick_in;
    end
  end

  assign tick_evt_c = tick_in & ~tick_q;

endmodule

// File: rtl/spi_tx_125k.sv
// SPI frame transmitter paced by the 125 kHz divider output.
// Sends one DATA_W-bit word per start on sclk/mosi framed by active-low cs_n.
// sclk idles low; mosi changes on sclk falling edges so it is stable at the
// rising edge. After the last bit, cs_n is raised and GAP_TICKS further
// events elapse before done pulses and the block returns to idle.
// Everything runs on clk_in; tick_in is only edge-detected.
//
// Build option:
//   SPI_TX_LSB_FIRST_EN defined   -> LSB first (mosi starts at data[0])
//   SPI_TX_LSB_FIRST_EN undefined -> MSB first (mosi starts at data[DATA_W-1])
//
// Ports:
//   clk_in  : 50 MHz system clock
//   rst     : synchronous reset, active-low
//   tick_in : 125 kHz divider output, each rising edge is one event
//   start   : frame request, sampled only while idle
//   data    : word to send, latched when start is accepted
//   busy    : high from the cycle after start acceptance until done
//   done    : one-cycle pulse at end of frame plus gap
//   sclk    : serial clock, idle low
//   mosi    : serial data
//   cs_n    : chip select, active-low
module spi_tx_125k
  import spi_tx_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned GAP_TICKS = 1
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              tick_in,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              mosi,
  output logic              cs_n
);

  localparam int unsigned CNT_W = cnt_w(DATA_W);
  localparam int unsigned GAP_W = $clog2(GAP_TICKS + 1);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP_TICKS - 1);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [GAP_W-1:0]  gap_cnt, gap_cnt_nxt;
  logic              sclk_nxt, mosi_nxt, cs_n_nxt, busy_nxt, done_nxt;

  logic              tick_evt_c;
  logic              load_bit_c;
  logic [DATA_W-1:0] load_rest_c;
  logic              next_bit_c;
  logic [DATA_W-1:0] shift_c;

  // Bit-rate event from the divider output.
  tick_edge_det u_tick_edge_det (
    .clk_in     (clk_in),
    .rst        (rst),
    .tick_in    (tick_in),
    .tick_evt_c (tick_evt_c)
  );

  // The shift register holds only the bits not yet on mosi: the first bit
  // goes straight to mosi at load, and each later bit is taken from the
  // outgoing end of the register as it shifts.
`ifdef SPI_TX_LSB_FIRST_EN
  assign load_bit_c  = data[0];
  assign load_rest_c = {1'b0, data[DATA_W-1:1]};
  assign next_bit_c  = shreg[0];
  assign shift_c     = {1'b0, shreg[DATA_W-1:1]};
`else
  assign load_bit_c  = data[DATA_W-1];
  assign load_rest_c = {data[DATA_W-2:0], 1'b0};
  assign next_bit_c  = shreg[DATA_W-1];
  assign shift_c     = {shreg[DATA_W-2:0], 1'b0};
`endif

  // State and registered outputs.
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      cs_n    <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      bit_cnt <= bit_cnt_nxt;
      gap_cnt <= gap_cnt_nxt;
      sclk    <= sclk_nxt;
      mosi    <= mosi_nxt;
      cs_n    <= cs_n_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

  // Next-state and next-output logic; non-event cycles hold everything.
  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    gap_cnt_nxt = gap_cnt;
    sclk_nxt    = sclk;
    mosi_nxt    = mosi;
    cs_n_nxt    = cs_n;
    busy_nxt    = busy;
    done_nxt    = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          shreg_nxt   = load_rest_c;
          mosi_nxt    = load_bit_c;
          cs_n_nxt    = 1'b0;
          busy_nxt    = 1'b1;
          bit_cnt_nxt = '0;
          state_nxt   = LOW;
        end
      end

      LOW: begin
        if (tick_evt_c) begin
          sclk_nxt  = 1'b1;
          state_nxt = HIGH;
        end
      end

      HIGH: begin
        if (tick_evt_c) begin
          sclk_nxt = 1'b0;
          if (bit_cnt == LAST_BIT) begin
            state_nxt = TRAIL;
          end else begin
            shreg_nxt   = shift_c;
            mosi_nxt    = next_bit_c;
            bit_cnt_nxt = CNT_W'(bit_cnt + 1'b1);
            state_nxt   = LOW;
          end
        end
      end

      TRAIL: begin
        if (tick_evt_c) begin
          cs_n_nxt    = 1'b1;
          mosi_nxt    = 1'b0;
          gap_cnt_nxt = '0;
          state_nxt   = GAP;
        end
      end

      GAP: begin
        if (tick_evt_c) begin
          gap_cnt_nxt = GAP_W'(gap_cnt + 1'b1);
          if (gap_cnt == LAST_GAP) begin
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_tx_125k.sv
// Directed bench for spi_tx_125k: reset/idle, basic frame, start while busy,
// reset mid-frame and back-to-back frames. Bit order follows the same build
// option as the design.
module tb_spi_tx_125k;

  localparam int unsigned DW         = 16;
  localparam int unsigned GT         = 1;
  localparam int unsigned FRAME_EVTS = 2 * DW + 1 + GT;

  // Hand-computed serial bit sequences (first bit on the left).
`ifdef SPI_TX_LSB_FIRST_EN
  localparam logic [15:0] EXP_A5C3 = 16'hC3A5;
  localparam logic [15:0] EXP_5A0F = 16'hF05A;
  localparam logic [15:0] EXP_1234 = 16'h2C48;
`else
  localparam logic [15:0] EXP_A5C3 = 16'hA5C3;
  localparam logic [15:0] EXP_5A0F = 16'h5A0F;
  localparam logic [15:0] EXP_1234 = 16'h1234;
`endif
  localparam logic [15:0] EXP_FFFF = 16'hFFFF;

  logic          clk_in  = 1'b0;
  logic          rst     = 1'b0;
  logic          tick_in = 1'b0;
  logic          start   = 1'b0;
  logic [DW-1:0] data    = '0;
  logic          busy, done, sclk, mosi, cs_n;

  int errors = 0;
  int checks = 0;

  int   tick_half = 200;
  int   tick_cnt  = 0;
  logic arm       = 1'b0;

  // Monitor state.
  logic          tick_prev   = 1'b1;
  int            evt_cnt     = 0;
  int            hi_evt      = 0;
  logic [4:0]    prev_o      = 5'b10000;
  int            rise_cnt    = 0;
  int            fall_cnt    = 0;
  int            done_cnt    = 0;
  int            act_cnt     = 0;
  int            cs_viol     = 0;
  int            rise_at_cs  = -1;
  int            fall_at_cs  = -1;
  int            evt_at_done = -1;
  int            hi_at_fall  = -1;
  logic [DW-1:0] cap         = '0;

  spi_tx_125k #(.DATA_W(DW), .GAP_TICKS(GT)) dut (
    .clk_in  (clk_in),
    .rst     (rst),
    .tick_in (tick_in),
    .start   (start),
    .data    (data),
    .busy    (busy),
    .done    (done),
    .sclk    (sclk),
    .mosi    (mosi),
    .cs_n    (cs_n)
  );

  always #5 clk_in = ~clk_in;

  // Divider stand-in: square wave with a programmable half period.
  always @(negedge clk_in) begin
    if (tick_cnt + 1 >= tick_half) begin
      tick_cnt = 0;
      tick_in  = ~tick_in;
    end else begin
      tick_cnt = tick_cnt + 1;
    end
  end

  // Event counting at the edge where the design samples its inputs.
  always @(posedge clk_in) begin
    if (arm) evt_cnt = 0;
    else if (tick_in && !tick_prev) evt_cnt = evt_cnt + 1;
    if (!cs_n) hi_evt = 0;
    else if (tick_in && !tick_prev) hi_evt = hi_evt + 1;
    tick_prev = tick_in;
  end

  // Output observation between active edges.
  always @(negedge clk_in) begin
    if (sclk && !prev_o[3]) begin
      rise_cnt = rise_cnt + 1;
      cap      = {cap[DW-2:0], mosi};
    end
    if (!sclk && prev_o[3]) fall_cnt = fall_cnt + 1;
    if (cs_n && !prev_o[4]) begin
      rise_at_cs = rise_cnt;
      fall_at_cs = fall_cnt;
    end
    if (!cs_n && prev_o[4]) hi_at_fall = hi_evt;
    if (sclk && cs_n) cs_viol = cs_viol + 1;
    if (done) begin
      done_cnt    = done_cnt + 1;
      evt_at_done = evt_cnt;
    end
    if ({cs_n, sclk, mosi, busy, done} !== prev_o) act_cnt = act_cnt + 1;
    prev_o = {cs_n, sclk, mosi, busy, done};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    rise_cnt    = 0;
    fall_cnt    = 0;
    cap         = '0;
    done_cnt    = 0;
    cs_viol     = 0;
    rise_at_cs  = -1;
    fall_at_cs  = -1;
    evt_at_done = -1;
    hi_at_fall  = -1;
  endtask

  // Request a frame; optionally pulse a second start at event poke_evt.
  // Returns in the cycle where done is high (or when the budget expires).
  task automatic send(input logic [DW-1:0] w, input int poke_evt);
    int n;
    bit poked;
    @(negedge clk_in); #1;
    clear_mon();
    data  = w;
    start = 1'b1;
    arm   = 1'b1;
    @(negedge clk_in); #1;
    start = 1'b0;
    arm   = 1'b0;
    n     = 0;
    poked = 1'b0;
    while (n < 4000 && done_cnt == 0) begin
      @(negedge clk_in); #1;
      n = n + 1;
      if (start) begin
        start = 1'b0;
      end else if (poke_evt != 0 && !poked && evt_cnt == poke_evt) begin
        start = 1'b1;
        data  = 16'h0001;
        poked = 1'b1;
      end
    end
    start = 1'b0;
    check("done_seen", 32'(done_cnt != 0), 32'd1);
  endtask

  task automatic check_frame(input string tag, input logic [DW-1:0] exp_bits, input bit settle);
    if (settle) begin
      @(negedge clk_in); #1;
    end
    check({tag, "_rises"},      32'(rise_cnt),    32'(DW));
    check({tag, "_bits"},       32'(cap),         32'(exp_bits));
    check({tag, "_cs_hi_rise"}, 32'(rise_at_cs),  32'(DW));
    check({tag, "_cs_hi_fall"}, 32'(fall_at_cs),  32'(DW));
    check({tag, "_cs_viol"},    32'(cs_viol),     32'd0);
    check({tag, "_done_cnt"},   32'(done_cnt),    32'd1);
    check({tag, "_done_evts"},  32'(evt_at_done), 32'(FRAME_EVTS));
  endtask

  initial begin
    int n;
    int a0;

    // Reset and idle with the real 125 kHz tick rate.
    rst = 1'b0;
    repeat (5) @(negedge clk_in);
    #1;
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b1;
    a0  = act_cnt;
    repeat (2000) @(negedge clk_in);
    #1;
    check("idle_activity", 32'(act_cnt - a0), 32'd0);

    // Faster tick for the frame tests.
    tick_half = 20;
    repeat (50) @(negedge clk_in);

    // Basic frame.
    send(16'hA5C3, 0);
    check_frame("basic", EXP_A5C3, 1'b1);

    // Start while busy: ignored, no second frame.
    send(16'hFFFF, 10);
    check_frame("busy", EXP_FFFF, 1'b1);
    repeat (300) @(negedge clk_in);
    #1;
    check("busy_no_2nd_rises", 32'(rise_cnt), 32'(DW));
    check("busy_no_2nd_busy",  32'(busy),     32'd0);
    check("busy_no_2nd_cs_n",  32'(cs_n),     32'd1);

    // Reset at the 7th sclk rise.
    @(negedge clk_in); #1;
    clear_mon();
    data  = 16'h5A0F;
    start = 1'b1;
    arm   = 1'b1;
    @(negedge clk_in); #1;
    start = 1'b0;
    arm   = 1'b0;
    n     = 0;
    while (rise_cnt < 7 && n < 4000) begin
      @(negedge clk_in); #1;
      n = n + 1;
    end
    check("mid_rst_rise7", 32'(rise_cnt), 32'd7);
    rst = 1'b0;
    @(negedge clk_in); #1;
    check("mid_rst_cs_n", 32'(cs_n), 32'd1);
    check("mid_rst_sclk", 32'(sclk), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    @(negedge clk_in); #1;
    rst = 1'b1;
    repeat (200) @(negedge clk_in);
    #1;
    check("mid_rst_no_done", 32'(done_cnt), 32'd0);
    send(16'h5A0F, 0);
    check_frame("after_rst", EXP_5A0F, 1'b1);

    // Back-to-back frames.
    send(16'h1234, 0);
    check_frame("b2b_a", EXP_1234, 1'b0);
    send(16'hFFFF, 0);
    check_frame("b2b_b", EXP_FFFF, 1'b1);
    check("b2b_gap_evts", 32'(hi_at_fall >= int'(GT)), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
